// File: rtl/i2s_slave_rx_os.sv
`timescale 1ns/1ps
// I2S slave receiver oversampled in the fabric clock: SCK/WS/SD are synchronised,
// slots are framed (Philips or left-justified), short slots zero-padded, SCK loss flagged.
module i2s_slave_rx_os #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2,
   parameter int MODE_LJ     = 0,
   parameter int TIMEOUT_W   = 8
) (
   input  logic              WBs_CLK_i,
   input  logic              WBs_RST_n_i,
   input  logic              i2s_clk_i,
   input  logic              i2s_ws_clk_i,
   input  logic              i2s_din_i,
   input  logic              I2S_S_EN_i,
   output logic [DATA_W-1:0] data_left_o,
   output logic [DATA_W-1:0] data_right_o,
   output logic              push_left_o,
   output logic              push_right_o,
   output logic [5:0]        slot_len_o,
   output logic              i2s_dis_o
);
   localparam logic [6:0] DW7 = 7'(DATA_W);

   logic [2:0]           sync_reg [SYNC_STAGES];
   logic                 sck_q_reg;
   logic                 sck_s;
   logic                 ws_s;
   logic                 sd_s;
   logic                 sck_rise;
   logic                 sck_edge;

   logic                 ws_q_reg;
   logic                 ws_seen_reg;
   logic                 pend_reg;
   logic                 armed_reg;
   logic                 chan_reg;
   logic [5:0]           cnt_reg;
   logic [DATA_W-1:0]    sr_reg;
   logic                 ws_chg;
   logic                 slot_start;
   logic                 chan_next;
   logic [6:0]           pad;
   logic [DATA_W-1:0]    closed;

   logic [TIMEOUT_W-1:0] tc_reg;

   assign sck_s    = sync_reg[SYNC_STAGES-1][0];
   assign ws_s     = sync_reg[SYNC_STAGES-1][1];
   assign sd_s     = sync_reg[SYNC_STAGES-1][2];
   assign sck_rise = sck_s & ~sck_q_reg;
   assign sck_edge = sck_s ^ sck_q_reg;

   // The first WS sample after reset/enable is only a reference level, not a transition.
   assign ws_chg     = ws_seen_reg && (ws_s != ws_q_reg);
   assign slot_start = sck_rise && ((MODE_LJ != 0) ? ws_chg : pend_reg);
   assign chan_next  = (MODE_LJ != 0) ? ws_s : ws_q_reg;

   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RST_n_i || !I2S_S_EN_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
         sck_q_reg <= 1'b0;
      end else begin
         sync_reg[0] <= {i2s_din_i, i2s_ws_clk_i, i2s_clk_i};
         for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
         sck_q_reg <= sck_s;
      end
   end

   always_comb begin
      pad    = DW7 - {1'b0, cnt_reg};
      closed = sr_reg;
      if ({1'b0, cnt_reg} < DW7) closed = sr_reg << pad;
   end

   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RST_n_i || !I2S_S_EN_i) begin
         ws_q_reg     <= 1'b0;
         ws_seen_reg  <= 1'b0;
         pend_reg     <= 1'b0;
         armed_reg    <= 1'b0;
         chan_reg     <= 1'b0;
         cnt_reg      <= 6'd0;
         sr_reg       <= '0;
         data_left_o  <= '0;
         data_right_o <= '0;
         push_left_o  <= 1'b0;
         push_right_o <= 1'b0;
         slot_len_o   <= 6'd0;
      end else begin
         push_left_o  <= 1'b0;
         push_right_o <= 1'b0;
         if (sck_rise) begin
            ws_q_reg    <= ws_s;
            ws_seen_reg <= 1'b1;
            pend_reg    <= (MODE_LJ == 0) && ws_chg;
            if (slot_start) begin
               if (armed_reg) begin
                  if (chan_reg) begin
                     data_right_o <= closed;
                     push_right_o <= 1'b1;
                  end else begin
                     data_left_o <= closed;
                     push_left_o <= 1'b1;
                  end
                  slot_len_o <= cnt_reg;
               end
               armed_reg <= 1'b1;
               chan_reg  <= chan_next;
               sr_reg    <= {{(DATA_W-1){1'b0}}, sd_s};
               cnt_reg   <= 6'd1;
            end else begin
               if ({1'b0, cnt_reg} < DW7) sr_reg <= {sr_reg[DATA_W-2:0], sd_s};
               if (cnt_reg != 6'd63) cnt_reg <= cnt_reg + 6'd1;
            end
         end
      end
   end

   // SCK-loss watchdog keeps running while disabled; only reset clears it.
   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RST_n_i) begin
         tc_reg    <= '0;
         i2s_dis_o <= 1'b0;
      end else begin
         if (sck_edge) tc_reg <= '0;
         else if (tc_reg != {TIMEOUT_W{1'b1}}) tc_reg <= tc_reg + TIMEOUT_W'(1);
         i2s_dis_o <= tc_reg[TIMEOUT_W-1];
      end
   end

endmodule

// File: tb/tb_i2s_slave_rx_os.sv
`timescale 1ns/1ps
// Scoreboard bench for i2s_slave_rx_os: four instances (I2S/16, LJ/16, I2S/16 on
// advanced data, I2S/24) driven by directed I2S streams with hand-computed pushes.
module tb_i2s_slave_rx_os;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, en_a, en_bc, en_d;
   logic sck_p [2];
   logic ws_p  [2];
   logic sd_p  [2];
   logic sd_adv;

   logic [15:0] a_dl, a_dr, b_dl, b_dr, c_dl, c_dr;
   logic [23:0] d_dl, d_dr;
   logic        a_pl, a_pr, b_pl, b_pr, c_pl, c_pr, d_pl, d_pr;
   logic [5:0]  a_len, b_len, c_len, d_len;
   logic        a_dis, b_dis, c_dis, d_dis;

   int total = 0;
   int bad   = 0;
   logic [38:0] sb [4][$];
   bit seg_ws [$];
   bit seg_lj [$];

   i2s_slave_rx_os #(.DATA_W(16), .MODE_LJ(0)) dut_a (
      .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .i2s_clk_i(sck_p[0]), .i2s_ws_clk_i(ws_p[0]),
      .i2s_din_i(sd_p[0]), .I2S_S_EN_i(en_a), .data_left_o(a_dl), .data_right_o(a_dr),
      .push_left_o(a_pl), .push_right_o(a_pr), .slot_len_o(a_len), .i2s_dis_o(a_dis));
   i2s_slave_rx_os #(.DATA_W(16), .MODE_LJ(1)) dut_b (
      .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .i2s_clk_i(sck_p[0]), .i2s_ws_clk_i(ws_p[0]),
      .i2s_din_i(sd_adv), .I2S_S_EN_i(en_bc), .data_left_o(b_dl), .data_right_o(b_dr),
      .push_left_o(b_pl), .push_right_o(b_pr), .slot_len_o(b_len), .i2s_dis_o(b_dis));
   i2s_slave_rx_os #(.DATA_W(16), .MODE_LJ(0)) dut_c (
      .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .i2s_clk_i(sck_p[0]), .i2s_ws_clk_i(ws_p[0]),
      .i2s_din_i(sd_adv), .I2S_S_EN_i(en_bc), .data_left_o(c_dl), .data_right_o(c_dr),
      .push_left_o(c_pl), .push_right_o(c_pr), .slot_len_o(c_len), .i2s_dis_o(c_dis));
   i2s_slave_rx_os #(.DATA_W(24), .MODE_LJ(0)) dut_d (
      .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .i2s_clk_i(sck_p[1]), .i2s_ws_clk_i(ws_p[1]),
      .i2s_din_i(sd_p[1]), .I2S_S_EN_i(en_d), .data_left_o(d_dl), .data_right_o(d_dr),
      .push_left_o(d_pl), .push_right_o(d_pr), .slot_len_o(d_len), .i2s_dis_o(d_dis));

   task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d actual=%0h required=%0h", name, id, act, exp);
      end
   endtask

   task automatic expect_push(input int id, input bit ch, input logic [31:0] d, input logic [5:0] len);
      sb[id].push_back({ch, len, d});
   endtask

   task automatic mon(input int id, input logic pl, input logic pr,
                      input logic [31:0] dl, input logic [31:0] dr, input logic [5:0] len);
      logic [38:0] e;
      if (pl || pr) begin
         chk("push_exclusive", id, {31'd0, pl & pr}, 32'd0);
         if (sb[id].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_push dut%0d actual=push_l%0d_r%0d required=none", id, pl, pr);
         end else begin
            e = sb[id].pop_front();
            chk("push_channel", id, {31'd0, pr}, {31'd0, e[38]});
            chk("push_data", id, pr ? dr : dl, e[31:0]);
            chk("slot_len", id, {26'd0, len}, {26'd0, e[37:32]});
            $display("dut%0d push %s data=%0h len=%0d", id, pr ? "right" : "left", pr ? dr : dl, len);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_pl, a_pr, 32'(a_dl), 32'(a_dr), a_len);
      mon(1, b_pl, b_pr, 32'(b_dl), 32'(b_dr), b_len);
      mon(2, c_pl, c_pr, 32'(c_dl), 32'(c_dr), c_len);
      mon(3, d_pl, d_pr, 32'(d_dl), 32'(d_dr), d_len);
   end

   // Slot content given left-aligned; the Philips SD pin lags it by one SCK.
   task automatic add_slot(input bit w, input logic [31:0] d, input int len);
      for (int i = 0; i < len; i++) begin
         seg_ws.push_back(w);
         seg_lj.push_back(d[31-i]);
      end
   endtask

   task automatic play(input int p, input bit ws_at_rise);
      for (int k = 0; k < seg_ws.size(); k++) begin
         @(posedge clk); #1;
         sck_p[p] = 1'b0;
         if (!ws_at_rise) ws_p[p] = seg_ws[k];
         sd_p[p] = (k == 0) ? 1'b0 : seg_lj[k-1];
         if (p == 0) sd_adv = seg_lj[k];
         repeat (3) @(posedge clk);
         #1;
         sck_p[p] = 1'b1;
         if (ws_at_rise) ws_p[p] = seg_ws[k];
         repeat (3) @(posedge clk);
      end
      seg_ws.delete();
      seg_lj.delete();
   endtask

   task automatic chk_zero_all(input string name);
      chk({name, "_dl"}, 0, 32'(a_dl), 0); chk({name, "_dr"}, 0, 32'(a_dr), 0);
      chk({name, "_len"}, 0, 32'(a_len), 0); chk({name, "_push"}, 0, {30'd0, a_pl, a_pr}, 0);
      chk({name, "_dis"}, 0, 32'(a_dis), 0);
      chk({name, "_dl"}, 1, 32'(b_dl), 0); chk({name, "_dis"}, 1, 32'(b_dis), 0);
      chk({name, "_dr"}, 2, 32'(c_dr), 0); chk({name, "_dis"}, 2, 32'(c_dis), 0);
      chk({name, "_dl"}, 3, 32'(d_dl), 0); chk({name, "_dis"}, 3, 32'(d_dis), 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; en_a = 1'b1; en_bc = 1'b1; en_d = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sck_p[i] = 1'b0; ws_p[i] = 1'b0; sd_p[i] = 1'b0;
      end
      sd_adv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero_all("reset");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // Test 1 / 3: Philips stream on A, same stream advanced one SCK on B (LJ) and C (Philips).
      expect_push(0, 0, 32'hA5C3, 32); expect_push(0, 1, 32'h3C5A, 32);
      expect_push(0, 0, 32'hA5C3, 32); expect_push(0, 1, 32'h3C5A, 32);
      expect_push(1, 0, 32'hA5C3, 32); expect_push(1, 1, 32'h3C5A, 32);
      expect_push(1, 0, 32'hA5C3, 32); expect_push(1, 1, 32'h3C5A, 32);
      expect_push(2, 0, 32'h4B86, 32); expect_push(2, 1, 32'h78B4, 32);
      expect_push(2, 0, 32'h4B86, 32); expect_push(2, 1, 32'h78B4, 32);
      add_slot(1, 32'h9999_0000, 32);
      add_slot(0, 32'hA5C3_0000, 32); add_slot(1, 32'h3C5A_0000, 32);
      add_slot(0, 32'hA5C3_0000, 32); add_slot(1, 32'h3C5A_0000, 32);
      add_slot(0, 32'hF00F_0000, 32);
      play(0, 1'b0);
      en_bc = 1'b0;

      // Test 4: SCK held high, then restarted.
      @(posedge clk); #1 sck_p[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1 sck_p[0] = 1'b1;
      n = 0;
      while (!a_dis && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("dis_rise_clocks", 0, 32'(n), 32'd132);
      @(posedge clk); #1 sck_p[0] = 1'b0;
      n = 0;
      while (a_dis && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("dis_fall_clocks", 0, 32'(n), 32'd4);

      // Test 5: enable dropped mid right slot; saturated slot closes first.
      expect_push(0, 0, 32'hF00F, 63);
      expect_push(0, 0, 32'h3333, 32); expect_push(0, 1, 32'h4444, 32);
      add_slot(0, 32'h1111_0000, 32); add_slot(1, 32'h2222_0000, 32);
      add_slot(0, 32'h3333_0000, 32); add_slot(1, 32'h4444_0000, 32);
      add_slot(0, 32'h5555_0000, 32);
      fork
         play(0, 1'b0);
         begin
            repeat (8 * 45) @(posedge clk);
            #1 en_a = 1'b0;
            @(posedge clk); #1;
            chk("dis_en_dl", 0, 32'(a_dl), 0);
            chk("dis_en_dr", 0, 32'(a_dr), 0);
            chk("dis_en_len", 0, 32'(a_len), 0);
            repeat (9) @(posedge clk);
            #1 en_a = 1'b1;
         end
      join

      // Test 6: WS toggled with SCK rise, reset mid-frame, glitch between edges.
      expect_push(0, 0, 32'h5555, 32);
      expect_push(0, 0, 32'h7E81, 32); expect_push(0, 1, 32'h8001, 32);
      expect_push(0, 0, 32'h1357, 32); expect_push(0, 1, 32'h2468, 32);
      add_slot(1, 32'h0F0F_0000, 32); add_slot(0, 32'h7E81_0000, 32);
      add_slot(1, 32'h8001_0000, 32); add_slot(0, 32'h1357_0000, 32);
      add_slot(1, 32'h2468_0000, 32); add_slot(0, 32'hAAAA_0000, 32);
      fork
         play(0, 1'b1);
         begin
            repeat (8 * 10) @(posedge clk);
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("rst_mid_dl", 0, 32'(a_dl), 0);
            chk("rst_mid_dr", 0, 32'(a_dr), 0);
            chk("rst_mid_len", 0, 32'(a_len), 0);
            chk("rst_mid_dis", 0, 32'(a_dis), 0);
            rst_n = 1'b1;
         end
         begin
            repeat (8 * 80) @(posedge clk);
            #2 rst_n = 1'b0;
            #5 rst_n = 1'b1;
            @(posedge clk); #1;
            chk("glitch_dl", 0, 32'(a_dl), 32'h7E81);
            chk("glitch_len", 0, 32'(a_len), 32'd32);
         end
      join

      // Test 2: 24-bit receiver with 16-SCK slots, zero-padded LSBs.
      expect_push(3, 0, 32'h123400, 16); expect_push(3, 1, 32'hBEEF00, 16);
      expect_push(3, 0, 32'h567800, 16);
      add_slot(1, 32'h0, 16); add_slot(0, 32'h1234_0000, 16);
      add_slot(1, 32'hBEEF_0000, 16); add_slot(0, 32'h5678_0000, 16);
      add_slot(1, 32'h0, 16);
      play(1, 1'b0);

      repeat (20) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) chk("pushes_missing", i, 32'(sb[i].size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i2s_slave_rx_os.md
Name: i2s_slave_rx_os

Overview:
- Parametrised successor to the fabric I2S slave receiver.
- Samples the external SCK, WS and SD pins in the single fabric clock domain, so no global clock buffer is spent on SCK.
- Supports Philips-I2S and left-justified framing, any sample width up to 32 bits, and automatic zero-padding of slots shorter than the sample width.
- Reports the measured slot length and raises an SCK-loss flag.
- Sits between the I2S pads and the per-channel RX FIFOs / Wishbone register block.

Parameters:
- DATA_W, 16: captured sample width in bits, MSB first; legal range 8..32.
- SYNC_STAGES, 2: synchroniser depth applied identically to SCK, WS and SD; legal range 2..3.
- MODE_LJ, 0: 0 = Philips I2S (MSB one SCK after the WS change); 1 = left-justified (MSB on the same SCK as the WS change).
- TIMEOUT_W, 8: width of the SCK-inactivity counter.

Ports:
- WBs_CLK_i, input, 1: fabric clock; the only clock.
- WBs_RST_n_i, input, 1: reset; synchronous, active-low.
- i2s_clk_i, input, 1: external bit clock (SCK), asynchronous.
- i2s_ws_clk_i, input, 1: word select; 0 = left, 1 = right.
- i2s_din_i, input, 1: serial data.
- I2S_S_EN_i, input, 1: receiver enable.
- data_left_o, output, DATA_W: last left sample.
- data_right_o, output, DATA_W: last right sample.
- push_left_o, output, 1: one-clock strobe; data_left_o is updated on the same edge.
- push_right_o, output, 1: one-clock strobe; data_right_o is updated on the same edge.
- slot_len_o, output, 6: SCK count of the last completed slot, saturating at 63.
- i2s_dis_o, output, 1: SCK-lost indicator.

Behaviour:
- Reset:
  - Applied on a WBs_CLK_i rising edge while WBs_RST_n_i = 0.
  - All flops clear; every output = 0.
  - No asynchronous path.
- Clocking constraint: WBs_CLK_i frequency >= 4x SCK frequency. Below this, behaviour is undefined.
- Synchroniser:
  - SCK, WS and SD each pass through SYNC_STAGES flops; all reset to 0.
  - sck_rise = sck_s & ~sck_q.
  - Any-edge signal: sck_edge = sck_s ^ sck_q.
  - WS and SD values are taken from the same synchroniser stage as sck_s.
- On each sck_rise: ws_q <= ws_s; ws_chg = (ws_s != ws_q).
- Slot start:
  - MODE_LJ = 1: the sck_rise at which ws_chg = 1.
  - MODE_LJ = 0: the first sck_rise after that one, tracked by a one-bit pending flag.
- At slot start, in this order:
  - Close the previous slot (see slot close).
  - Clear bit counter cnt[5:0] and the shift register.
  - Latch the channel: left if ws_q = 0, else right.
  - Shift in SD as bit 0 of the new slot; cnt = 1.
- Other sck_rise:
  - If cnt < DATA_W: shift SD in LSB-first into position, MSB first overall.
  - cnt increments, saturating at 63.
  - Bits beyond DATA_W are ignored.
- Slot close, evaluated only if the armed flag is set:
  - If cnt >= DATA_W: output = shift register.
  - If cnt < DATA_W: output = shift register << (DATA_W - cnt), LSBs zero.
  - Write the result to data_left_o or data_right_o per the latched channel.
  - Pulse the matching push for exactly one clock, 1 WBs clock after the detecting sck_rise.
  - slot_len_o <= cnt on the same edge.
- Armed flag:
  - Set at the first slot start after enable/reset. The partial first slot is never pushed.
  - Cleared by reset or by I2S_S_EN_i = 0.
- push_left_o and push_right_o are never asserted together.
- Data outputs hold until the next push of their own channel.
- I2S_S_EN_i = 0 (sampled on the clock edge):
  - Synchroniser, frame logic, data outputs, pushes and slot_len_o clear on the next edge.
  - A slot in progress is discarded.
  - After re-enable, the first push follows the second slot start.
- SCK-loss counter tc[TIMEOUT_W-1:0]:
  - Cleared on sck_edge; otherwise increments, saturating at all-ones.
  - i2s_dis_o is registered tc[TIMEOUT_W-1]: asserts 2^(TIMEOUT_W-1)+1 clocks after the last edge.
  - Deasserts 2 clocks after an edge reaches sck_edge.
  - Counts regardless of I2S_S_EN_i; cleared only by reset.
- Simultaneous ws_chg and EN falling edge: enable wins, no push.

Test Plan:
1. I2S mode, DATA_W=16, 32-SCK slots, WBs:SCK = 8:1, WS starting at 1. Stream left 0xA5C3, right 0x3C5A, two frames.
   - Required: no push for the first partial slot.
   - Required: push_left_o with 0xA5C3, then push_right_o with 0x3C5A, each one clock wide.
   - Required: slot_len_o = 32.
2. DATA_W=24, 16-SCK slots, left 0x1234.
   - Required: data_left_o = 0x123400; slot_len_o = 16.
3. MODE_LJ=1, same waveform as test 1 with data advanced one SCK.
   - Required: identical captured values.
   - Re-run with MODE_LJ=0 to confirm the one-bit offset: expected 0x4B86.
4. Stop SCK high, TIMEOUT_W=8.
   - Required: i2s_dis_o rises exactly 129 clocks after the last synchronised edge.
   - Restart SCK. Required: i2s_dis_o falls 2 clocks after the first edge reaches sck_edge.
5. Drop I2S_S_EN_i mid-slot for 10 clocks, then re-enable.
   - Required: outputs = 0 on the next edge; no push for the interrupted or the next partial slot.
   - Required: the first push carries a complete sample.
6. Reset and WS/SCK timing.
   - Drive WBs_RST_n_i low for 3 clocks mid-frame. Required: all outputs = 0 and the armed flag clear.
   - Drive a low pulse between clock edges only. Required: no effect.
   - Toggle WS at the SCK-rise instant. Required: exactly one slot boundary.
